round_scheduler: RTL and testbench

Sequencing controller for the light-memory game core. Owns the round phases: show the sequence, accept player input, show GOOD, end. Generates the difficulty-scaled game tick that paces the core, and tracks level and difficulty. Sits between top-level start/reset controls and the game core; the core reports completion and pass/fail back through pulses.

---
 rtl/round_sched_pkg.sv | 19 +
 rtl/round_scheduler_tick_gen.sv | 28 ++
 rtl/round_scheduler.sv | 109 ++++++++++
 tb/tb_round_scheduler.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/round_sched_pkg.sv
// round_sched_pkg: phase encoding and tick-period helper shared by the round scheduler
package round_sched_pkg;

    localparam int PHASE_W = 3;

    typedef enum logic [PHASE_W-1:0] {
        IDLE  = 3'd0,
        SHOW  = 3'd1,
        INPUT = 3'd2,
        GOOD  = 3'd3,
        END   = 3'd4
    } phase_t;

    // Tick period in clk cycles for a given difficulty step
    function automatic int tick_period(input int base, input int step, input logic [1:0] diff);
        return base - int'(diff) * step;
    endfunction

endpackage

// File: rtl/round_scheduler_tick_gen.sv
// tick_gen: down-counting game-pace strobe; restart reloads so the first tick lands a full period later
module tick_gen #(
    parameter int W = 10
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         run,
    input  logic         restart,
    input  logic [W-1:0] period,
    output logic         tick
);

    logic [W-1:0] cnt;

    // Count down while running, strobe and reload at zero; restart wins over counting
    always_ff @(posedge clk) begin
        if (reset || restart) begin
            cnt  <= period - W'(1);
            tick <= 1'b0;
        end else if (run) begin
            cnt  <= (cnt == '0) ? period - W'(1) : cnt - W'(1);
            tick <= (cnt == '0);
        end else begin
            tick <= 1'b0;
        end
    end

endmodule

// File: rtl/round_scheduler.sv
// round_scheduler: round-phase FSM, difficulty-scaled tick and level/difficulty tracking for the light-memory game
// Optional LEVEL_BCD_EN: drive level as two packed BCD digits instead of binary.
module round_scheduler
    import round_sched_pkg::*;
#(
    parameter int BASE_PERIOD     = 1000,
    parameter int PERIOD_STEP     = 250,
    parameter int LEVELS_PER_DIFF = 2,
    parameter int INPUT_TIMEOUT   = 16,
    parameter int GOOD_TICKS      = 2,
    parameter int MAX_LEVEL       = 99
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               core_show_done,
    input  logic               core_input_ok,
    input  logic               core_input_fail,
    output logic               tick,
    output logic [PHASE_W-1:0] phase,
    output logic               core_start_show,
    output logic               core_start_input,
    output logic [7:0]         level,
    output logic [1:0]         difficulty,
    output logic               game_over,
    output logic               busy
);

    localparam int TW = $clog2(BASE_PERIOD + 1);

    phase_t        state, state_next;
    logic [15:0]   to_cnt, good_cnt;
    logic [7:0]    lvl, lvl_inc, lvl_next;
    logic [1:0]    diff_next;
    logic [TW-1:0] period;
    logic          restart, new_game, enter_good;

    function automatic logic [7:0] enc(input logic [7:0] b);
`ifdef LEVEL_BCD_EN
        return {4'(b / 8'd10), 4'(b % 8'd10)};
`else
        return b;
`endif
    endfunction

    assign restart    = state_next != state;
    assign new_game   = (state == IDLE || state == END) && start;
    assign enter_good = state == INPUT && state_next == GOOD;
    assign lvl_inc    = (lvl >= 8'(MAX_LEVEL)) ? 8'(MAX_LEVEL) : lvl + 8'd1;
    assign period     = TW'(tick_period(BASE_PERIOD, PERIOD_STEP, reset ? 2'd0 : difficulty));
    assign phase      = state;
    assign busy       = state == SHOW || state == INPUT || state == GOOD;
    assign game_over  = state == END;

    tick_gen #(.W(TW)) u_tick (
        .clk     (clk),
        .reset   (reset),
        .run     (busy),
        .restart (restart),
        .period  (period),
        .tick    (tick)
    );

    // Next phase: fail beats ok, and any result beats a coincident timeout tick
    always_comb begin
        state_next = state;
        case (state)
            IDLE, END: state_next = start ? SHOW : state;
            SHOW:      state_next = core_show_done ? INPUT : SHOW;
            INPUT:     state_next = core_input_fail ? END :
                                    core_input_ok ? GOOD :
                                    (tick && to_cnt == 16'(INPUT_TIMEOUT - 1)) ? END : INPUT;
            GOOD:      state_next = (tick && good_cnt == 16'(GOOD_TICKS - 1)) ? SHOW : GOOD;
            default:   state_next = IDLE;
        endcase
    end

    // Level and difficulty after a new game or a cleared round
    always_comb begin
        lvl_next  = new_game ? 8'd1 : enter_good ? lvl_inc : lvl;
        diff_next = new_game ? 2'd0 :
                    (enter_good && (lvl_inc - 8'd1) % 8'(LEVELS_PER_DIFF) == 8'd0 && difficulty != 2'd3) ?
                    difficulty + 2'd1 : difficulty;
    end

    // State, bookkeeping, per-phase tick counters and entry pulses
    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= IDLE;
            lvl              <= 8'd1;
            level            <= enc(8'd1);
            difficulty       <= 2'd0;
            to_cnt           <= '0;
            good_cnt         <= '0;
            core_start_show  <= 1'b0;
            core_start_input <= 1'b0;
        end else begin
            state            <= state_next;
            lvl              <= lvl_next;
            level            <= enc(lvl_next);
            difficulty       <= diff_next;
            to_cnt           <= restart ? '0 : (state == INPUT && tick) ? to_cnt + 16'd1 : to_cnt;
            good_cnt         <= restart ? '0 : (state == GOOD && tick) ? good_cnt + 16'd1 : good_cnt;
            core_start_show  <= restart && state_next == SHOW;
            core_start_input <= restart && state_next == INPUT;
        end
    end

endmodule

// File: tb/tb_round_scheduler.sv
// tb_round_scheduler: scoreboard bench for round_scheduler (BASE_PERIOD=8, PERIOD_STEP=2); honours LEVEL_BCD_EN
module tb_round_scheduler;
    import round_sched_pkg::*;

    logic       clk = 1'b0, reset = 1'b1, start = 1'b0;
    logic       core_show_done = 1'b0, core_input_ok = 1'b0, core_input_fail = 1'b0;
    logic       tick, core_start_show, core_start_input, game_over, busy;
    logic [2:0] phase;
    logic [7:0] level;
    logic [1:0] difficulty;

    int vectors = 0, miscompares = 0;
    int exp_q[$];
    int m_level, m_diff, n, s0;
    int show_cnt = 0, input_cnt = 0;

    round_scheduler #(
        .BASE_PERIOD(8), .PERIOD_STEP(2), .LEVELS_PER_DIFF(2),
        .INPUT_TIMEOUT(16), .GOOD_TICKS(2), .MAX_LEVEL(99)
    ) dut (
        .clk(clk), .reset(reset), .start(start),
        .core_show_done(core_show_done), .core_input_ok(core_input_ok), .core_input_fail(core_input_fail),
        .tick(tick), .phase(phase), .core_start_show(core_start_show), .core_start_input(core_start_input),
        .level(level), .difficulty(difficulty), .game_over(game_over), .busy(busy)
    );

    always #5 clk = ~clk;

    // Count entry pulses as they are seen on clock edges
    always @(posedge clk) begin
        show_cnt  <= show_cnt + int'(core_start_show);
        input_cnt <= input_cnt + int'(core_start_input);
    end

    function automatic int enc(input int v);
`ifdef LEVEL_BCD_EN
        return ((v / 10) << 4) | (v % 10);
`else
        return v;
`endif
    endfunction

    task automatic check(input string tag, input int got_v, input int want);
        vectors++;
        if (got_v != want) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", tag, got_v, want);
        end
    endtask

    task automatic push_exp(input int v);
        exp_q.push_back(v);
    endtask

    task automatic got(input string tag, input int v);
        if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL %s: got %0d, scoreboard empty", tag, v);
        end else begin
            check(tag, v, exp_q.pop_front());
        end
    endtask

    task automatic drive(input bit st, input bit sd, input bit ok, input bit fl);
        start = st; core_show_done = sd; core_input_ok = ok; core_input_fail = fl;
        @(negedge clk);
        start = 0; core_show_done = 0; core_input_ok = 0; core_input_fail = 0;
    endtask

    task automatic wait_tick(output int cycles);
        cycles = 0;
        do begin
            @(negedge clk);
            cycles++;
        end while (!tick && cycles < 200);
        check("tick_wait", int'(tick), 1);
    endtask

    task automatic check_reset_state();
        push_exp(IDLE); push_exp(0); push_exp(0); push_exp(0);
        push_exp(enc(1)); push_exp(0); push_exp(0); push_exp(0);
        got("rst_phase", phase);
        got("rst_tick", tick);
        got("rst_start_show", core_start_show);
        got("rst_start_input", core_start_input);
        got("rst_level", level);
        got("rst_diff", difficulty);
        got("rst_game_over", game_over);
        got("rst_busy", busy);
    endtask

    task automatic enter_input();
        push_exp(INPUT);
        drive(0, 1, 0, 0);
        got("phase_input", phase);
    endtask

    task automatic new_game();
        m_level = 1;
        m_diff  = 0;
        push_exp(SHOW); push_exp(enc(1)); push_exp(0);
        drive(1, 0, 0, 0);
        got("phase_start", phase);
        got("start_level", level);
        got("start_diff", difficulty);
    endtask

    // Play one round to GOOD (optionally answering on the timeout tick) and back to SHOW
    task automatic clear_level(input bit late);
        int i0, p;
        i0 = input_cnt;
        enter_input();
        if (late) begin
            repeat (16) wait_tick(p);
            push_exp(INPUT);
            got("input_at_timeout_tick", phase);
        end
        m_level = (m_level < 99) ? m_level + 1 : 99;
        if ((m_level - 1) % 2 == 0 && m_diff < 3) m_diff++;
        push_exp(GOOD); push_exp(enc(m_level)); push_exp(m_diff);
        drive(0, 0, 1, 0);
        got("phase_good", phase);
        got("good_level", level);
        got("good_diff", difficulty);
        check("input_pulses", input_cnt - i0, 1);
        wait_tick(p);
        push_exp(GOOD);
        got("good_hold", phase);
        wait_tick(p);
        @(negedge clk);
        push_exp(SHOW); push_exp(8 - 2 * m_diff);
        got("phase_reshow", phase);
        wait_tick(p);
        got("show_period", p);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check_reset_state();
        reset = 0;
        @(negedge clk);

        s0 = show_cnt;
        m_level = 1;
        m_diff  = 0;
        push_exp(SHOW); push_exp(1); push_exp(enc(1)); push_exp(0); push_exp(8);
        drive(1, 0, 0, 0);
        got("phase_show", phase);
        got("start_show_pulse", core_start_show);
        got("level_init", level);
        got("diff_init", difficulty);
        wait_tick(n);
        got("first_tick", n);
        check("show_pulses", show_cnt - s0, 1);

        push_exp(SHOW); push_exp(enc(1));
        drive(1, 0, 1, 1);
        got("busy_ignores", phase);
        got("busy_level", level);

        clear_level(0);

        enter_input();
        push_exp(END); push_exp(1); push_exp(enc(2)); push_exp(0);
        drive(0, 0, 1, 1);
        got("fail_wins", phase);
        got("game_over", game_over);
        got("fail_level", level);
        got("end_busy", busy);

        new_game();
        enter_input();
        repeat (15) wait_tick(n);
        push_exp(INPUT);
        got("timeout_15", phase);
        wait_tick(n);
        @(negedge clk);
        push_exp(END); push_exp(1);
        got("timeout_end", phase);
        got("timeout_game_over", game_over);
        repeat (10) @(negedge clk);
        push_exp(0);
        got("end_no_tick", tick);

        new_game();
        clear_level(1);
        for (int i = 0; i < 10; i++) clear_level(0);
        push_exp(enc(12)); push_exp(3);
        got("level_12", level);
        got("diff_sat", difficulty);

        enter_input();
        reset = 1;
        @(negedge clk);
        check_reset_state();
        reset = 0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
